// File: rtl/hi14a_pkg.sv
// Shared types and constants for the ISO14443-A receive core.
// Holds the operating-mode codes, default sizing constants and the
// filter output width helper.
package hi14a_pkg;

   typedef enum logic [2:0] {
      MODE_SNIFFER       = 3'd0,
      MODE_TAGSIM_LISTEN = 3'd1,
      MODE_TAGSIM_MOD    = 3'd2,
      MODE_READER_LISTEN = 3'd3,
      MODE_READER_MOD    = 3'd4
   } mode_t;

   localparam int unsigned ADC_W_DEF    = 8;
   localparam int unsigned WIN_LOG2_DEF = 4;

   // Filter output width: 2*a + b - (2*c + d) needs three extra bits, signed.
   function automatic int unsigned filt_w(input int unsigned adc_w);
      return adc_w + 3;
   endfunction

endpackage

// File: rtl/hi14a_edge_filter.sv
// Derivative filter: four-deep sample history and
// y = (2*x4 + x3) - (2*x + x1), signed, one tick of history per clock.
// Ports:
//   i_clk  clock (rising edge)
//   i_rst  synchronous active-high reset
//   i_x    current unsigned ADC sample
//   o_y    signed filter output for the current sample (combinational)
module hi14a_edge_filter
   import hi14a_pkg::*;
#(
   parameter int unsigned ADC_W = ADC_W_DEF,
   parameter int unsigned YW    = filt_w(ADC_W)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [ADC_W-1:0]     i_x,
   output logic signed [YW-1:0] o_y
);

   logic [ADC_W-1:0] r_x1, r_x2, r_x3, r_x4;
   logic [YW-1:0]    w_old;
   logic [YW-1:0]    w_new;

   // Sample history, x1 newest.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_x1 <= '0;
         r_x2 <= '0;
         r_x3 <= '0;
         r_x4 <= '0;
      end else begin
         r_x1 <= i_x;
         r_x2 <= r_x1;
         r_x3 <= r_x2;
         r_x4 <= r_x3;
      end
   end

   // Both partial sums are non-negative and fit in YW bits; the difference
   // wraps into a correct two's-complement result.
   assign w_old = (YW'(r_x4) << 1) + YW'(r_x3);
   assign w_new = (YW'(i_x) << 1) + YW'(r_x1);
   assign o_y   = $signed(w_old - w_new);

endmodule

// File: rtl/hi_iso14443a_rx_core.sv
// ISO14443-A HF receive core: tag-modulation detector, reader-pause
// hysteresis comparator, byte packer and SSP serialiser to the ARM.
// Optional feature macro: HI14A_SNIFF_EN (sniffer byte = {reader, tag}).
// Ports:
//   ck_1356meg  carrier clock, all logic on rising edge
//   rst         synchronous active-high reset
//   mod_type    operating mode, captured at frame boundaries
//   adc_d       unsigned ADC sample
//   edge_thr    unsigned edge threshold
//   det_phase   in-window tick where the detector decides and clears
//   hyst_hi/lo  reader-on / reader-off levels
//   ssp_dout    ARM modulation bit
//   ssp_clk/ssp_frame/ssp_din  SSP link to the ARM
//   mod_sig_coil registered ssp_dout; carrier_en reader carrier enable
//   curbit      latest tag-modulation decision; dbg window half marker
module hi_iso14443a_rx_core
   import hi14a_pkg::*;
#(
   parameter int unsigned ADC_W    = ADC_W_DEF,
   parameter int unsigned WIN_LOG2 = WIN_LOG2_DEF,
   parameter int unsigned THR_W    = 8
) (
   input  logic                ck_1356meg,
   input  logic                rst,
   input  logic [2:0]          mod_type,
   input  logic [ADC_W-1:0]    adc_d,
   input  logic [THR_W-1:0]    edge_thr,
   input  logic [WIN_LOG2-1:0] det_phase,
   input  logic [ADC_W-1:0]    hyst_hi,
   input  logic [ADC_W-1:0]    hyst_lo,
   input  logic                ssp_dout,
   output logic                ssp_clk,
   output logic                ssp_frame,
   output logic                ssp_din,
   output logic                mod_sig_coil,
   output logic                carrier_en,
   output logic                curbit,
   output logic                dbg
);

   localparam int unsigned YW     = filt_w(ADC_W);
   localparam int unsigned CW     = WIN_LOG2 + 3;
   localparam int unsigned W      = 1 << WIN_LOG2;
   localparam int unsigned BYTE_W = 8;
   localparam logic signed [YW-1:0] Y_ZERO = '0;

   logic [CW-1:0]          r_cnt;
   logic [2:0]             r_mode_q;
   logic signed [YW-1:0]   r_fall_max, r_rise_min;
   logic                   r_curbit, r_rd;
   logic [BYTE_W-1:0]      r_acc, r_tx;
   logic                   r_ssp_clk, r_ssp_frame, r_ssp_din;
   logic                   r_mod_sig_coil, r_carrier_en;

   logic signed [YW-1:0]   w_y, w_thr, w_nthr;
   logic [WIN_LOG2-1:0]    w_win;
   logic                   w_bound, w_win0, w_whalf;
   logic                   w_shift_bit, w_sniff;
   logic [BYTE_W-1:0]      w_sniff_byte;

   assign w_win   = r_cnt[WIN_LOG2-1:0];
   assign w_bound = (r_cnt == '0);
   assign w_win0  = (w_win == '0);
   assign w_whalf = (w_win == WIN_LOG2'(W / 2));

   // Threshold is an unsigned magnitude; widen with zero fill.
   assign w_thr  = $signed(YW'(edge_thr));
   assign w_nthr = -w_thr;

   hi14a_edge_filter #(.ADC_W(ADC_W), .YW(YW)) u_filt (
      .i_clk (ck_1356meg),
      .i_rst (rst),
      .i_x   (adc_d),
      .o_y   (w_y)
   );

   // Free-running tick counter and mode capture at frame boundaries.
   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         r_cnt    <= '0;
         r_mode_q <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
         if (w_bound) r_mode_q <= mod_type;
      end
   end

   // Edge-pair detector: a window needs both a fall and a rise beyond thr.
   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         r_fall_max <= '0;
         r_rise_min <= '0;
         r_curbit   <= 1'b0;
      end else if (w_win == det_phase) begin
         r_curbit   <= (r_fall_max > w_thr) && (r_rise_min < w_nthr);
         r_fall_max <= '0;
         r_rise_min <= '0;
      end else if (w_y > Y_ZERO) begin
         if (w_y > r_fall_max) r_fall_max <= w_y;
      end else if (w_y < r_rise_min) begin
         r_rise_min <= w_y;
      end
   end

   // Reader-pause hysteresis; the "on" test has priority.
   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         r_rd <= 1'b1;
      end else if (adc_d >= hyst_hi) begin
         r_rd <= 1'b1;
      end else if (adc_d <= hyst_lo) begin
         r_rd <= 1'b0;
      end
   end

   assign w_shift_bit = (r_mode_q == MODE_READER_LISTEN) & r_curbit;

`ifdef HI14A_SNIFF_EN
   logic [3:0] r_reader_q, r_tag_q;

   assign w_sniff = (r_mode_q == MODE_SNIFFER);

   // Sniffer samples on even windows only: four reader and four tag bits.
   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         r_reader_q <= '0;
         r_tag_q    <= '0;
      end else if (w_sniff && w_win0 && !r_cnt[WIN_LOG2]) begin
         r_reader_q <= {r_reader_q[2:0], r_rd};
         r_tag_q    <= {r_tag_q[2:0], r_curbit};
      end
   end

   assign w_sniff_byte = {r_reader_q, r_tag_q};
`else
   assign w_sniff      = 1'b0;
   assign w_sniff_byte = '0;
`endif

   // Byte packing and serial shift-out, one bit per window, MSB first.
   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         r_acc <= '0;
         r_tx  <= '0;
      end else if (w_win0) begin
         r_tx <= w_bound ? r_acc : {r_tx[BYTE_W-2:0], 1'b0};
         if (!w_sniff)     r_acc <= {r_acc[BYTE_W-2:0], w_shift_bit};
         else if (w_bound) r_acc <= w_sniff_byte;
      end
   end

   // SSP strobes, data and coil / carrier drive.
   always_ff @(posedge ck_1356meg) begin
      if (rst) begin
         r_ssp_clk      <= 1'b0;
         r_ssp_frame    <= 1'b0;
         r_ssp_din      <= 1'b0;
         r_mod_sig_coil <= 1'b0;
         r_carrier_en   <= 1'b0;
      end else begin
         if (w_win0)       r_ssp_clk <= 1'b1;
         else if (w_whalf) r_ssp_clk <= 1'b0;
         if (r_cnt == CW'(W / 2 - 1))          r_ssp_frame <= 1'b1;
         else if (r_cnt == CW'(W / 2 - 1 + W)) r_ssp_frame <= 1'b0;
         r_ssp_din      <= r_tx[BYTE_W-1];
         r_mod_sig_coil <= ssp_dout;
         r_carrier_en   <= (r_mode_q == MODE_READER_LISTEN) |
                           ((r_mode_q == MODE_READER_MOD) & ~ssp_dout);
      end
   end

   assign ssp_clk      = r_ssp_clk;
   assign ssp_frame    = r_ssp_frame;
   assign ssp_din      = r_ssp_din;
   assign mod_sig_coil = r_mod_sig_coil;
   assign carrier_en   = r_carrier_en;
   assign curbit       = r_curbit;
   assign dbg          = r_cnt[WIN_LOG2-1];

endmodule
